// File: rtl/seq_control_unit_if.sv
// Handshake/strobe bundle between the instruction register, the sequencer and the datapath.
// With SEQ_STEP_EN defined the bundle also carries the single-step strobe.
interface seq_control_unit_if #(
    parameter int unsigned NT  = 6,
    parameter int unsigned OPW = 4
);
    logic           run_en;
    logic           resume;
    logic [OPW-1:0] opcode;
    logic           gt_flag;
    logic           zero_flag;
`ifdef SEQ_STEP_EN
    logic           step;
`endif
    logic [13:0]    ctrl;
    logic [NT-1:0]  tstate;
    logic           halted;
    logic           instr_done;

    // master: the sequencer itself; slave: the IR/datapath side
    modport master (
`ifdef SEQ_STEP_EN
        input  step,
`endif
        input  run_en, resume, opcode, gt_flag, zero_flag,
        output ctrl, tstate, halted, instr_done
    );

    modport slave (
`ifdef SEQ_STEP_EN
        output step,
`endif
        output run_en, resume, opcode, gt_flag, zero_flag,
        input  ctrl, tstate, halted, instr_done
    );
endinterface

// File: rtl/seq_control_unit.sv
// SAP-style control sequencer: internal one-hot T-state ring, microcode decode, HALT/resume.
// Optional single-step gating is enabled by defining SEQ_STEP_EN.
module seq_control_unit #(
    parameter int unsigned NT  = 6,
    parameter int unsigned OPW = 4
) (
    input  logic                clk,
    input  logic                reset,
    seq_control_unit_if.master  bus
);
    if (NT < 6) begin : g_nt_check
        $error("seq_control_unit: NT must be >= 6");
    end

    localparam logic [13:0] LP  = 14'h2000;
    localparam logic [13:0] EP  = 14'h1000;
    localparam logic [13:0] LM  = 14'h0800;
    localparam logic [13:0] EPR = 14'h0400;
    localparam logic [13:0] LI  = 14'h0200;
    localparam logic [13:0] EI  = 14'h0100;
    localparam logic [13:0] LA  = 14'h0080;
    localparam logic [13:0] EA  = 14'h0040;
    localparam logic [13:0] NEG = 14'h0020;
    localparam logic [13:0] EV  = 14'h0010;
    localparam logic [13:0] LB  = 14'h0008;
    localparam logic [13:0] LO  = 14'h0004;
    localparam logic [13:0] CO  = 14'h0002;
    localparam logic [13:0] PO  = 14'h0001;
    localparam logic [NT-1:0] T0 = NT'(1);

    typedef enum logic [0:0] {RUN, HALT} state_e;
    typedef enum logic [3:0] {
        OP_MOV, OP_ADD, OP_SUB, OP_JZ, OP_JGT, OP_JMP, OP_OUT, OP_HLT, OP_NOP
    } op_e;

    state_e        state_q, state_d;
    logic [NT-1:0] tstate_q, tstate_d;
    logic [13:0]   ctrl_w;
    logic          done_w;
    logic          legal;
    logic          step_ok;
    logic [31:0]   op_ext;
    op_e           op;

`ifdef SEQ_STEP_EN
    // load strobes only; enable strobes stay visible between steps
    localparam logic [13:0] LOAD_MASK = LP | LM | LI | LA | LB | LO | PO;
    assign step_ok = bus.step;
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            tstate_q <= T0;
        end else begin
            state_q  <= state_d;
            tstate_q <= tstate_d;
        end
    end

    always_comb begin
        op_ext = 32'(bus.opcode);
        case (op_ext)
            32'h0:   op = OP_MOV;
            32'h3:   op = OP_ADD;
            32'h4:   op = OP_SUB;
            32'h5:   op = OP_JZ;
            32'h6:   op = OP_JGT;
            32'h7:   op = OP_JMP;
            32'hE:   op = OP_OUT;
            32'hF:   op = OP_HLT;
            default: op = OP_NOP;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        tstate_d = tstate_q;
        ctrl_w   = '0;
        done_w   = 1'b0;
        legal    = (tstate_q != '0) && ((tstate_q & (tstate_q - NT'(1))) == '0);

        if (!legal) begin
            state_d  = RUN;
            tstate_d = T0;
        end else if (state_q == HALT) begin
            if (bus.resume && step_ok) begin
                state_d  = RUN;
                tstate_d = T0;
            end
        end else if (bus.run_en) begin
            if (tstate_q[0]) begin
                ctrl_w = EP | LM;
            end else if (tstate_q[1]) begin
                ctrl_w = EPR | LI;
            end else if (tstate_q[2]) begin
                ctrl_w = LP;
                done_w = (op == OP_NOP);
            end else if (tstate_q[3]) begin
                done_w = 1'b1;
                case (op)
                    OP_MOV, OP_ADD, OP_SUB: begin
                        ctrl_w = EI | LM;
                        done_w = 1'b0;
                    end
                    OP_JZ:   ctrl_w = EI | (bus.zero_flag ? PO : 14'h0);
                    OP_JGT:  ctrl_w = EI | CO | (bus.gt_flag ? PO : 14'h0);
                    OP_JMP:  ctrl_w = EI | PO;
                    OP_OUT:  ctrl_w = EA | LO;
                    default: ctrl_w = '0;
                endcase
            end else if (tstate_q[4]) begin
                done_w = 1'b1;
                case (op)
                    OP_MOV:         ctrl_w = EPR | LA;
                    OP_ADD, OP_SUB: begin
                        ctrl_w = EPR | LB;
                        done_w = 1'b0;
                    end
                    default:        ctrl_w = '0;
                endcase
            end else if (tstate_q[5]) begin
                done_w = 1'b1;
                case (op)
                    OP_ADD:  ctrl_w = EV | LA;
                    OP_SUB:  ctrl_w = EV | NEG | LA;
                    default: ctrl_w = '0;
                endcase
            end else begin
                done_w = 1'b1;
            end

            // HLT parks on T3 rather than wrapping to T0
            if (step_ok) begin
                if (done_w && op == OP_HLT && tstate_q[3]) begin
                    state_d = HALT;
                end else if (done_w) begin
                    tstate_d = T0;
                end else begin
                    tstate_d = {tstate_q[NT-2:0], 1'b0};
                end
            end
        end
    end

`ifdef SEQ_STEP_EN
    assign bus.ctrl = step_ok ? ctrl_w : (ctrl_w & ~LOAD_MASK);
`else
    assign bus.ctrl = ctrl_w;
`endif
    assign bus.tstate     = tstate_q;
    assign bus.halted     = (state_q == HALT);
    assign bus.instr_done = done_w;
endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
- Next-generation SAP-style control sequencer for the 8-bit CPU.
- Generates its own T-state ring counter internally; no external t0..t5 inputs.
- Supports variable-length instructions with early end-of-instruction, flag-conditional jumps, and a real HALT state with resume.
- Sits between the instruction register (opcode field) and the datapath load/enable strobes.

Parameters:
NT, 6, number of T-states in the ring (one-hot width); must be >= 6.
OPW, 4, opcode width; values above 4'hF decode as NOP.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
run_en  in  1  advance enable; low = stall, tstate held, ctrl forced 0
resume  in  1  leave HALT and restart at T0
opcode  in  OPW  instruction register high field
gt_flag  in  1  ALU A>B flag, for JGT
zero_flag  in  1  ALU zero flag, for JZ
ctrl  out  14  control word, bits [13:0] = lp ep lm epr li ei la ea n ev lb lo co po
tstate  out  NT  one-hot current T-state
halted  out  1  high while in HALT
instr_done  out  1  high during the last T-state of an instruction

Behaviour:
- Reset state: tstate = 1 (T0), halted = 0, RUN state.
  - ctrl = ep|lm (the T0 word).
  - instr_done = 0.
- tstate is a registered one-hot counter; ctrl and instr_done decode combinationally from tstate, opcode and the flags.
- FSM states: RUN, HALT.
- In RUN with run_en = 1, tstate advances one position per clk.
  - When instr_done = 1, tstate returns to T0 on the next clk instead of advancing.
- Fetch, opcode-independent:
  - T0: ep, lm.
  - T1: epr, li.
  - T2: lp.
- Execute microcode; the last listed T-state asserts instr_done:
  - 0000 MOV: T3 ei, lm; T4 epr, la.
  - 0011 ADD: T3 ei, lm; T4 epr, lb; T5 ev, la.
  - 0100 SUB: T3 ei, lm; T4 epr, lb; T5 ev, n, la.
  - 0101 JZ: T3 ei, plus po only if zero_flag = 1.
  - 0110 JGT: T3 ei, co, plus po only if gt_flag = 1.
  - 0111 JMP: T3 ei, po.
  - 1110 OUT: T3 ea, lo.
  - 1111 HLT: T3 asserts no strobes. The next clk enters HALT.
  - Any other opcode: NOP, instr_done at T2.
- Flag sampling: flags are read combinationally in T3 only; changes in other T-states have no effect.
- HALT:
  - ctrl = 0, halted = 1, tstate held at T3, instr_done = 0.
  - resume = 1 → next clk: RUN, tstate = T0, halted = 0.
  - resume in RUN is ignored.
- Stall: run_en = 0 holds tstate with ctrl = 0. instr_done = 0 during a stall.
- Priority: reset > resume > run_en.
  - Reset mid-instruction aborts at once: next cycle is T0.
  - Reset in HALT clears halted.
- A T-state beyond the opcode's last state (NT > 6 padding) is unreachable. If reached, it behaves as NOP with instr_done = 1.
- Exactly one of tstate's bits is set at all times. Any illegal pattern recovers to T0 on the next clk.

Optional Feature:
SEQ_STEP_EN
- Defined:
  - Adds input port step (1 bit).
  - tstate advances, and the HALT→T0 transition completes, only on clk edges where step = 1 (and run_en = 1 for advancing).
  - Load strobes lp, lm, li, la, lb, lo, po are gated by step, so each register loads at most once per step. Enable strobes are not gated.
- Not defined: step port absent; sequencer runs freely per run_en.

Test Plan:
- Reset, then opcode=0011 with run_en=1 → tstate 1,2,4,8,16,32,1. ctrl T5 = ev|la. instr_done high in T5 only.
- opcode=0110: gt_flag=0 → T3 ctrl = ei|co with po=0, then T0. gt_flag=1 → T3 ctrl includes po=1. Instruction length 4 cycles in both cases.
- opcode=1111 → after T3, halted=1 and ctrl=0 for 10 cycles. Pulse resume → next cycle tstate=1, halted=0, ctrl=ep|lm.
- opcode=0100: drop run_en at T4 for 3 cycles → tstate stays 16 with ctrl=0. Restore run_en → T4 word epr|lb, then T5 ev|n|la.
- Assert reset in T4 of MOV → next cycle tstate=1. Assert reset together with resume in HALT → halted=0, tstate=1.
- With SEQ_STEP_EN: step pulsed every 3rd cycle → tstate advances once per pulse. la is high only in the step cycle of MOV T4.
